// File: rtl/reg_readout_serializer.sv
// Register readout serializer: snapshots a DATA_WIDTH-bit word on request
// and streams it out LSB slice first as OUT_WIDTH-bit beats over valid/ready.
// Every output comes straight from a flop, so nothing combinational reaches
// the pins from i_out_ready or i_capture_req.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for i_capture_req; all beat outputs held at zero
// SEND  | presenting shadow beat 'beat'; advances on each handshake
// DONE  | one-cycle o_done pulse, then back to IDLE unconditionally
module reg_readout_serializer #(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  i_capture_req,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_busy,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [OUT_WIDTH-1:0]  o_out_data,
    output logic                  o_out_last,
    output logic                  o_done
);

    localparam int NBEATS = DATA_WIDTH / OUT_WIDTH;
    localparam int BEAT_W = $clog2(NBEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [DATA_WIDTH-1:0]   shadow_q, shadow_d;
    logic                    busy_q, busy_d;
    logic                    out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0]    out_data_q, out_data_d;
    logic                    out_last_q, out_last_d;
    logic                    done_q, done_d;
    logic [OUT_WIDTH-1:0]    beat_slice;

    // Next-state logic; outputs are derived from the next state so that the
    // registered outputs line up with the state they describe.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        shadow_d = shadow_q;

        case (state_q)
            IDLE: begin
                if (i_capture_req) begin
                    shadow_d = i_data;
                    beat_d   = '0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (i_out_ready) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = DONE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        beat_slice = '0;
        for (int i = 0; i < NBEATS; i++) begin
            if (beat_d == BEAT_W'(i)) begin
                beat_slice = shadow_d[i*OUT_WIDTH +: OUT_WIDTH];
            end
        end

        busy_d      = (state_d != IDLE);
        out_valid_d = (state_d == SEND);
        out_data_d  = (state_d == SEND) ? beat_slice : '0;
        out_last_d  = (state_d == SEND) && (beat_d == LAST_BEAT);
        done_d      = (state_d == DONE);
    end

    // State and registered outputs; synchronous reset wins over everything.
    always_ff @(posedge clk) begin
        if (arst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            shadow_q    <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            shadow_q    <= shadow_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

    assign o_busy      = busy_q;
    assign o_out_valid = out_valid_q;
    assign o_out_data  = out_data_q;
    assign o_out_last  = out_last_q;
    assign o_done      = done_q;

endmodule

// File: doc/reg_readout_serializer.md
# reg_readout_serializer

Read-side companion to the write-enabled pipeline registers. It captures a DATA_WIDTH-bit register value on request and streams it out as OUT_WIDTH-bit beats, least-significant slice first, over a valid/ready handshake. It sits between internal state registers and the narrow TinyTapeout output pins, and is used for debug and observation readout.

## Interface
- DATA_WIDTH, 32, width of the captured register word; must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 8, width of each output beat.
- NBEATS, derived, equals DATA_WIDTH/OUT_WIDTH; must be at least 2.
- clk  input  1  clock; all state updates on the rising edge.
- arst  input  1  reset, synchronous, active-high; clock clk.
- i_capture_req  input  1  request to snapshot i_data and start a readout.
- i_data  input  DATA_WIDTH  register value to read.
- o_busy  output  1  high in any state other than IDLE.
- o_out_valid  output  1  beat on o_out_data is valid.
- i_out_ready  input  1  consumer accepts the beat.
- o_out_data  output  OUT_WIDTH  current beat.
- o_out_last  output  1  current beat is beat NBEATS-1.
- o_done  output  1  one-cycle pulse after the final beat is accepted.

## Operation
- State machine: IDLE, SEND, DONE.
- IDLE: if i_capture_req is high on an edge:
  - shadow <= i_data
  - beat counter <= 0
  - go to SEND
- SEND:
  - o_out_valid = 1.
  - o_out_data = shadow[beat*OUT_WIDTH +: OUT_WIDTH].
  - o_out_last = (beat == NBEATS-1).
  - On an edge with i_out_ready = 1 (handshake): if last, go to DONE; otherwise beat <= beat+1.
  - Without i_out_ready: hold the beat, the data and last unchanged.
- DONE: o_done = 1 for exactly this one cycle, then unconditionally go to IDLE.
- i_capture_req is ignored in SEND and DONE (no queueing). The shadow register is not modified during a readout, even if i_data changes.
- Outputs outside SEND: o_out_valid = 0, o_out_last = 0, o_out_data = '0.
- Beat counter width is $clog2(NBEATS). It never wraps: it is reset to 0 on capture.
- All outputs are decoded from registered state only. There is no combinational path from i_out_ready or i_capture_req to any output.

## Timing
- Reset (arst high on an edge) forces:
  - state = IDLE
  - beat = 0
  - shadow = '0
  - o_busy = 0, o_out_valid = 0, o_out_last = 0, o_out_data = '0, o_done = 0
- Reset takes priority over every other event. An abort mid-SEND or in DONE returns to IDLE with no o_done pulse.
- Capture on edge N: o_busy and o_out_valid are high from cycle N+1, with beat 0 presented.
- With i_out_ready held high, beat k is presented in cycle N+1+k. The last handshake happens at the edge ending cycle N+NBEATS, and o_done is high in cycle N+NBEATS+1.
- A new capture is accepted at the earliest on the edge ending the first IDLE cycle after DONE. Minimum request-to-request spacing is NBEATS+2 cycles.
- Capture request in the same cycle as reset: reset wins, and the request is lost.
- Backpressure of any length: o_out_data and o_out_last remain stable while o_out_valid is high and i_out_ready is low (AXI-style valid rule). o_out_valid never drops until the handshake completes.

## Test plan
- Basic readout, DATA_WIDTH=32, OUT_WIDTH=8:
  - Stimulus: capture 0xDEADBEEF, i_out_ready tied to 1.
  - Required: beats 0xEF, 0xBE, 0xAD, 0xDE on 4 consecutive cycles; o_out_last only on 0xDE; o_done pulses once, one cycle later; o_busy low the cycle after.
- Backpressure:
  - Stimulus: capture 0x12345678, i_out_ready toggled 0,0,1,0,1,1,0,1.
  - Required: beats 0x78, 0x56, 0x34, 0x12 each held stable while ready is low; exactly 4 handshakes; o_done after the 0x12 handshake.
- Snapshot isolation:
  - Stimulus: capture 0xA5A5A5A5; change i_data to 0xFFFFFFFF and pulse i_capture_req during SEND and during DONE.
  - Required: all beats are 0xA5; the extra requests are ignored; no second readout starts.
- Reset mid-operation:
  - Stimulus: assert arst after the second beat is accepted.
  - Required: the next cycle shows all outputs 0 and no o_done; a following capture of 0x0000C0DE yields 0xDE, 0xC0, 0x00, 0x00.
- Back-to-back:
  - Stimulus: hold i_capture_req high continuously with ready=1, i_data = 0x11223344 then 0x55667788.
  - Required: the second readout's first beat appears exactly NBEATS+2 cycles after the first readout's first beat.
- Parameter variant:
  - Stimulus: DATA_WIDTH=16, OUT_WIDTH=4, capture 0xBEEF.
  - Required: beats 0xF, 0xE, 0xE, 0xB; o_out_last on the fourth beat.
